// File: rtl/line_rd_pkg.sv
// Shared types for the camera line FIFO read-side controller.
package line_rd_pkg;

   typedef enum logic [0:0] {
      StWaitSync,
      StRun
   } rd_state_e;

   localparam int unsigned DefLineLen = 1280;
   localparam int unsigned DefLines   = 720;

   // The line FIFO is 1 bit wide; the WIDTH parameter of the top must equal this.
   localparam int unsigned PixWidth = 1;

   typedef struct packed {
      logic [PixWidth-1:0] data;
      logic                sol;
      logic                eol;
      logic                sof;
      logic                eof;
   } beat_t;

endpackage

// File: rtl/beat_buf2.sv
// Two-entry in-order buffer of tagged beats; entry 0 is always the head.
module beat_buf2
   import line_rd_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  beat_t      din,
   input  logic       pop,
   input  logic       flush,
   output beat_t      head,
   output logic [1:0] occ
);

   beat_t      ent0_q, ent0_d;
   beat_t      ent1_q, ent1_d;
   logic [1:0] occ_q, occ_d;

   always_comb begin
      ent0_d = ent0_q;
      ent1_d = ent1_q;
      occ_d  = occ_q;
      if (flush) begin
         occ_d = 2'd0;
      end else begin
         unique case ({push, pop})
            2'b10: begin
               if (occ_q == 2'd0) ent0_d = din;
               else               ent1_d = din;
               occ_d = occ_q + 2'd1;
            end
            2'b01: begin
               ent0_d = ent1_q;
               occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
               // Occupancy unchanged; the new beat lands behind whatever stays.
               if (occ_q == 2'd1) begin
                  ent0_d = din;
               end else begin
                  ent0_d = ent1_q;
                  ent1_d = din;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent0_q <= '0;
         ent1_q <= '0;
         occ_q  <= 2'd0;
      end else begin
         ent0_q <= ent0_d;
         ent1_q <= ent1_d;
         occ_q  <= occ_d;
      end
   end

   assign head = ent0_q;
   assign occ  = occ_q;

endmodule

// File: rtl/line_fifo_reader.sv
// Drains the camera line FIFO into a valid/ready stream tagged with line/frame markers.
module line_fifo_reader
   import line_rd_pkg::*;
#(
   parameter int unsigned WIDTH    = PixWidth,
   parameter int unsigned LINE_LEN = DefLineLen,
   parameter int unsigned LINES    = DefLines
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sync,
   input  logic             fifo_empty,
   input  logic             fifo_full,
   input  logic [WIDTH-1:0] fifo_dout,
   output logic             fifo_rd_en,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             m_sol,
   output logic             m_eol,
   output logic             m_sof,
   output logic             m_eof,
   output logic             ovf_err,
   input  logic             err_clr
);

   localparam int unsigned PixW  = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
   localparam int unsigned LineW = (LINES > 1) ? $clog2(LINES) : 1;
   localparam logic [PixW-1:0]  PixLast  = PixW'(LINE_LEN - 1);
   localparam logic [LineW-1:0] LineLast = LineW'(LINES - 1);

   rd_state_e        state_q, state_d;
   logic [PixW-1:0]  pix_q, pix_d;
   logic [LineW-1:0] line_q, line_d;
   logic             inflight_q, inflight_d;
   logic             ovf_q, ovf_d;

   beat_t      cap_beat;
   beat_t      head;
   logic [1:0] occ;
   logic       pop_req;

   assign m_valid = (occ != 2'd0);
   assign pop_req = m_valid && m_ready;

   // A pop in this cycle frees a slot at the same edge, which sustains one beat per cycle.
   assign fifo_rd_en = (state_q == StRun) && !fifo_empty &&
                       (({1'b0, occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop_req}));

   always_comb begin
      cap_beat.data = fifo_dout;
      cap_beat.sol  = (pix_q == '0);
      cap_beat.eol  = (pix_q == PixLast);
      cap_beat.sof  = (pix_q == '0) && (line_q == '0);
      cap_beat.eof  = (pix_q == PixLast) && (line_q == LineLast);
   end

   always_comb begin
      state_d    = state_q;
      pix_d      = pix_q;
      line_d     = line_q;
      inflight_d = 1'b0;
      ovf_d      = ovf_q && !err_clr;
      if (fifo_full) begin
         // The FIFO is wiping itself: drop everything and wait for the next frame.
         state_d = StWaitSync;
         pix_d   = '0;
         line_d  = '0;
         ovf_d   = 1'b1;
      end else begin
         inflight_d = fifo_rd_en;
         unique case (state_q)
            StWaitSync: begin
               if (sync) begin
                  state_d = StRun;
                  pix_d   = '0;
                  line_d  = '0;
               end
            end
            StRun: begin
               if (inflight_q) begin
                  if (pix_q == PixLast) begin
                     pix_d  = '0;
                     line_d = (line_q == LineLast) ? '0 : line_q + LineW'(1);
                  end else begin
                     pix_d = pix_q + PixW'(1);
                  end
               end
            end
            default: state_d = StWaitSync;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StWaitSync;
         pix_q      <= '0;
         line_q     <= '0;
         inflight_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pix_q      <= pix_d;
         line_q     <= line_d;
         inflight_q <= inflight_d;
         ovf_q      <= ovf_d;
      end
   end

   beat_buf2 u_buf (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (inflight_q && !fifo_full),
      .din   (cap_beat),
      .pop   (pop_req && !fifo_full),
      .flush (fifo_full),
      .head  (head),
      .occ   (occ)
   );

   assign m_data  = head.data;
   assign m_sol   = head.sol;
   assign m_eol   = head.eol;
   assign m_sof   = head.sof;
   assign m_eof   = head.eof;
   assign ovf_err = ovf_q;

endmodule

// File: tb/tb_line_fifo_reader.sv
// Randomized bench for line_fifo_reader with a behavioural FIFO and stream reference model.
module tb_line_fifo_reader;

   localparam int W     = 1;
   localparam int LL    = 4;
   localparam int NL    = 2;
   localparam int FRAME = LL * NL;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         sync = 1'b0;
   logic         fifo_full = 1'b0;
   logic         m_ready = 1'b0;
   logic         err_clr = 1'b0;
   logic         fifo_empty;
   logic [W-1:0] fifo_dout = '0;
   logic         fifo_rd_en, m_valid, m_sol, m_eol, m_sof, m_eof, ovf_err;
   logic [W-1:0] m_data;

   int checks = 0;
   int errors = 0;

   line_fifo_reader #(.WIDTH(W), .LINE_LEN(LL), .LINES(NL)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sync       (sync),
      .fifo_empty (fifo_empty),
      .fifo_full  (fifo_full),
      .fifo_dout  (fifo_dout),
      .fifo_rd_en (fifo_rd_en),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_sol      (m_sol),
      .m_eol      (m_eol),
      .m_sof      (m_sof),
      .m_eof      (m_eof),
      .ovf_err    (ovf_err),
      .err_clr    (err_clr)
   );

   always #5 clk = ~clk;

   // Behavioural line FIFO: test side writes mem/wr_ptr, read side owns rd_ptr.
   logic [W-1:0] mem [0:255];
   int           wr_ptr = 0;
   int           rd_ptr = 0;
   logic         acc_n = 1'b0;
   logic         full_n = 1'b0;
   assign fifo_empty = (rd_ptr == wr_ptr);

   initial forever begin
      @(posedge clk);
      if (full_n) rd_ptr <= wr_ptr;
      else if (acc_n) begin
         fifo_dout <= mem[rd_ptr];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   // Observer: records handshakes, accepted reads and stream-rule violations.
   typedef struct {
      int           cyc;
      logic [W-1:0] data;
      logic         sol, eol, sof, eof;
   } beat_rec_t;

   beat_rec_t got[$];
   int        rd_cyc[$];
   int        ncyc = 0;
   int        outst = 0;
   int        viol_outst = 0;
   int        viol_stab = 0;
   logic      prev_stall = 1'b0;
   beat_rec_t prev_b;
   beat_rec_t cur;

   initial forever begin
      @(negedge clk);
      ncyc++;
      acc_n  = fifo_rd_en && !fifo_empty;
      full_n = fifo_full;
      if (!rst_n || fifo_full) begin
         outst      = 0;
         prev_stall = 1'b0;
      end else begin
         cur.cyc = ncyc; cur.data = m_data;
         cur.sol = m_sol; cur.eol = m_eol; cur.sof = m_sof; cur.eof = m_eof;
         if (prev_stall && (!m_valid || cur.data !== prev_b.data || cur.sol !== prev_b.sol ||
             cur.eol !== prev_b.eol || cur.sof !== prev_b.sof || cur.eof !== prev_b.eof))
            viol_stab++;
         if (m_valid && m_ready) got.push_back(cur);
         if (acc_n) rd_cyc.push_back(ncyc);
         outst = outst + int'(acc_n) - int'(m_valid && m_ready);
         if (outst > 2) viol_outst++;
         prev_stall = m_valid && !m_ready;
         prev_b     = cur;
      end
   end

   // Reference: the k-th beat after sync sits at pixel k%LL of line (k/LL)%NL.
   logic [W-1:0] exp_px[$];

   function automatic logic [3:0] exp_marks(int k);
      int p = k % LL;
      int l = (k / LL) % NL;
      return {p == 0, p == LL - 1, (p == 0) && (l == 0), (p == LL - 1) && (l == NL - 1)};
   endfunction

   task automatic step(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic load_pixels(int n);
      for (int i = 0; i < n; i++) begin
         logic [W-1:0] v;
         v = W'($urandom);
         mem[wr_ptr] = v;
         wr_ptr++;
         exp_px.push_back(v);
      end
   endtask

   task automatic apply_reset();
      #2 rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(1);
   endtask

   task automatic pulse_sync();
      sync = 1'b1;
      step(1);
      sync = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({fifo_rd_en, m_valid, m_data, m_sol, m_eol, m_sof, m_eof, ovf_err} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %b need all zero",
                  {fifo_rd_en, m_valid, m_data, m_sol, m_eol, m_sof, m_eof, ovf_err});
      end
      rst_n = 1'b1;
      load_pixels(1);
      step(4);
      checks++;
      if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_read_before_sync: rd_en %b valid %b need 0 0",
                  fifo_rd_en, m_valid);
      end
      // Drain the stray pixel through a full-clear so later tests start with an empty FIFO.
      fifo_full = 1'b1;
      step(1);
      fifo_full = 1'b0;
      exp_px.delete();
   endtask

   task automatic test_stream();
      int base, rbase, vbase;
      apply_reset();
      exp_px.delete();
      load_pixels(FRAME);
      m_ready = 1'b1;
      base = got.size(); rbase = rd_cyc.size(); vbase = viol_outst;
      pulse_sync();
      for (int c = 0; c < 40 && got.size() < base + FRAME; c++) step(1);
      checks++;
      if (got.size() - base != FRAME) begin
         errors++;
         $display("FAIL stream_count: got %0d beats need %0d", got.size() - base, FRAME);
      end else begin
         for (int i = 0; i < FRAME; i++) begin
            checks++;
            if (got[base+i].data !== exp_px[i] || got[base+i].cyc != got[base].cyc + i ||
                {got[base+i].sol, got[base+i].eol, got[base+i].sof, got[base+i].eof}
                !== exp_marks(i)) begin
               errors++;
               $display("FAIL stream_beat%0d: got d=%b m=%b cyc+%0d need d=%b m=%b cyc+%0d", i,
                        got[base+i].data, {got[base+i].sol, got[base+i].eol, got[base+i].sof,
                        got[base+i].eof}, got[base+i].cyc - got[base].cyc, exp_px[i],
                        exp_marks(i), i);
            end
         end
         checks++;
         if (rd_cyc.size() <= rbase || got[base].cyc - rd_cyc[rbase] != 2) begin
            errors++;
            $display("FAIL stream_latency: got %0d need 2",
                     (rd_cyc.size() > rbase) ? got[base].cyc - rd_cyc[rbase] : -1);
         end
      end
      checks++;
      if (viol_outst != vbase) begin
         errors++;
         $display("FAIL stream_outstanding: got %0d violations need 0", viol_outst - vbase);
      end
   endtask

   task automatic test_toggle();
      int base, sbase, vbase;
      apply_reset();
      exp_px.delete();
      load_pixels(FRAME);
      m_ready = 1'b1;
      base = got.size(); sbase = viol_stab; vbase = viol_outst;
      pulse_sync();
      for (int c = 0; c < 60 && got.size() < base + FRAME; c++) begin
         m_ready = ~m_ready;
         step(1);
      end
      checks++;
      if (got.size() - base != FRAME) begin
         errors++;
         $display("FAIL toggle_count: got %0d beats need %0d", got.size() - base, FRAME);
      end else begin
         for (int i = 0; i < FRAME; i++) begin
            checks++;
            if (got[base+i].data !== exp_px[i] ||
                {got[base+i].sol, got[base+i].eol, got[base+i].sof, got[base+i].eof}
                !== exp_marks(i)) begin
               errors++;
               $display("FAIL toggle_beat%0d: got d=%b m=%b need d=%b m=%b", i, got[base+i].data,
                        {got[base+i].sol, got[base+i].eol, got[base+i].sof, got[base+i].eof},
                        exp_px[i], exp_marks(i));
            end
         end
      end
      checks++;
      if (viol_stab != sbase || viol_outst != vbase) begin
         errors++;
         $display("FAIL toggle_stable: got stab %0d outst %0d violations need 0 0",
                  viol_stab - sbase, viol_outst - vbase);
      end
   endtask

   task automatic test_stall();
      int base, rbase;
      apply_reset();
      exp_px.delete();
      load_pixels(FRAME);
      m_ready = 1'b0;
      base = got.size(); rbase = rd_cyc.size();
      pulse_sync();
      step(10);
      checks++;
      if (rd_cyc.size() - rbase != 2 || fifo_rd_en !== 1'b0 || m_valid !== 1'b1 ||
          m_data !== exp_px[0]) begin
         errors++;
         $display("FAIL stall_hold: got reads %0d rd_en %b valid %b d=%b need 2 0 1 %b",
                  rd_cyc.size() - rbase, fifo_rd_en, m_valid, m_data, exp_px[0]);
      end
      m_ready = 1'b1;
      for (int c = 0; c < 40 && got.size() < base + FRAME; c++) step(1);
      checks++;
      if (got.size() - base != FRAME) begin
         errors++;
         $display("FAIL stall_count: got %0d beats need %0d", got.size() - base, FRAME);
      end else begin
         for (int i = 0; i < FRAME; i++) begin
            checks++;
            if (got[base+i].data !== exp_px[i] || got[base+i].cyc != got[base].cyc + i) begin
               errors++;
               $display("FAIL stall_beat%0d: got d=%b cyc+%0d need d=%b cyc+%0d", i,
                        got[base+i].data, got[base+i].cyc - got[base].cyc, exp_px[i], i);
            end
         end
      end
   endtask

   task automatic test_random();
      int base, sbase, vbase;
      apply_reset();
      exp_px.delete();
      load_pixels(2 * FRAME);
      base = got.size(); sbase = viol_stab; vbase = viol_outst;
      pulse_sync();
      for (int c = 0; c < 300 && got.size() < base + 2 * FRAME; c++) begin
         m_ready = ($urandom_range(0, 3) != 0);
         step(1);
      end
      checks++;
      if (got.size() - base != 2 * FRAME) begin
         errors++;
         $display("FAIL random_count: got %0d beats need %0d", got.size() - base, 2 * FRAME);
      end else begin
         for (int i = 0; i < 2 * FRAME; i++) begin
            checks++;
            if (got[base+i].data !== exp_px[i] ||
                {got[base+i].sol, got[base+i].eol, got[base+i].sof, got[base+i].eof}
                !== exp_marks(i)) begin
               errors++;
               $display("FAIL random_beat%0d: got d=%b m=%b need d=%b m=%b", i, got[base+i].data,
                        {got[base+i].sol, got[base+i].eol, got[base+i].sof, got[base+i].eof},
                        exp_px[i], exp_marks(i));
            end
         end
      end
      checks++;
      if (viol_stab != sbase || viol_outst != vbase) begin
         errors++;
         $display("FAIL random_rules: got stab %0d outst %0d violations need 0 0",
                  viol_stab - sbase, viol_outst - vbase);
      end
   endtask

   task automatic test_overflow();
      int base, rbase;
      apply_reset();
      exp_px.delete();
      load_pixels(FRAME);
      m_ready = 1'b1;
      base = got.size();
      pulse_sync();
      for (int c = 0; c < 20 && got.size() < base + 2; c++) step(1);
      fifo_full = 1'b1;
      step(1);
      fifo_full = 1'b0;
      checks++;
      if (ovf_err !== 1'b1 || m_valid !== 1'b0 || fifo_rd_en !== 1'b0) begin
         errors++;
         $display("FAIL ovf_flush: got ovf %b valid %b rd_en %b need 1 0 0",
                  ovf_err, m_valid, fifo_rd_en);
      end
      exp_px.delete();
      load_pixels(FRAME);
      rbase = rd_cyc.size();
      step(5);
      checks++;
      if (rd_cyc.size() != rbase || m_valid !== 1'b0) begin
         errors++;
         $display("FAIL ovf_wait_sync: got reads %0d valid %b need 0 0",
                  rd_cyc.size() - rbase, m_valid);
      end
      base = got.size();
      pulse_sync();
      for (int c = 0; c < 40 && got.size() < base + FRAME; c++) step(1);
      checks++;
      if (got.size() - base != FRAME) begin
         errors++;
         $display("FAIL ovf_resync_count: got %0d beats need %0d", got.size() - base, FRAME);
      end else begin
         for (int i = 0; i < FRAME; i++) begin
            checks++;
            if (got[base+i].data !== exp_px[i] ||
                {got[base+i].sol, got[base+i].eol, got[base+i].sof, got[base+i].eof}
                !== exp_marks(i)) begin
               errors++;
               $display("FAIL ovf_resync_beat%0d: got d=%b m=%b need d=%b m=%b", i,
                        got[base+i].data, {got[base+i].sol, got[base+i].eol, got[base+i].sof,
                        got[base+i].eof}, exp_px[i], exp_marks(i));
            end
         end
      end
      checks++;
      if (ovf_err !== 1'b1) begin
         errors++;
         $display("FAIL ovf_sticky: got %b need 1", ovf_err);
      end
   endtask

   task automatic test_err_clr();
      apply_reset();
      checks++;
      if (ovf_err !== 1'b0) begin
         errors++;
         $display("FAIL errclr_reset: got %b need 0", ovf_err);
      end
      fifo_full = 1'b1;
      step(1);
      fifo_full = 1'b0;
      checks++;
      if (ovf_err !== 1'b1) begin
         errors++;
         $display("FAIL errclr_set: got %b need 1", ovf_err);
      end
      fifo_full = 1'b1;
      err_clr   = 1'b1;
      step(1);
      fifo_full = 1'b0;
      err_clr   = 1'b0;
      checks++;
      if (ovf_err !== 1'b1) begin
         errors++;
         $display("FAIL errclr_full_wins: got %b need 1", ovf_err);
      end
      err_clr = 1'b1;
      step(1);
      err_clr = 1'b0;
      checks++;
      if (ovf_err !== 1'b0) begin
         errors++;
         $display("FAIL errclr_clear: got %b need 0", ovf_err);
      end
   endtask

   task automatic test_async_reset();
      int rbase;
      apply_reset();
      exp_px.delete();
      load_pixels(FRAME);
      m_ready = 1'b0;
      pulse_sync();
      step(6);
      checks++;
      if (m_valid !== 1'b1) begin
         errors++;
         $display("FAIL arst_buffered: got valid %b need 1", m_valid);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({fifo_rd_en, m_valid, m_data, m_sol, m_eol, m_sof, m_eof, ovf_err} !== '0) begin
         errors++;
         $display("FAIL arst_immediate: got %b need all zero",
                  {fifo_rd_en, m_valid, m_data, m_sol, m_eol, m_sof, m_eof, ovf_err});
      end
      step(1);
      rst_n   = 1'b1;
      m_ready = 1'b1;
      rbase   = rd_cyc.size();
      step(6);
      checks++;
      if (rd_cyc.size() != rbase || fifo_rd_en !== 1'b0 || m_valid !== 1'b0) begin
         errors++;
         $display("FAIL arst_needs_sync: got reads %0d rd_en %b valid %b need 0 0 0",
                  rd_cyc.size() - rbase, fifo_rd_en, m_valid);
      end
      pulse_sync();
      step(3);
      checks++;
      if (rd_cyc.size() == rbase) begin
         errors++;
         $display("FAIL arst_resume: got 0 reads after sync need at least 1");
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_toggle();
      test_stall();
      test_random();
      test_overflow();
      test_err_clr();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
